mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequenced arbiter that shares one single-ported unified memory between the processor's instruction-fetch path and its load/store data path. It accepts one request at a time, drives the memory port until the memory signals ready (or a timeout expires), and returns read data with a one-cycle completion pulse to the winning requester. Data requests have priority over fetch, with a starvation guard for fetch. It sits between the CPU core (PC_out/inst_in on one side, Addr_out/Data_out/wea/Data_in on the other) and the memory/MIO bus.

## Interface

- TIMEOUT_CYCLES, 255: maximum BUSY cycles without mem_ready before forced error completion (legal range 2..255).
- STARVE_MAX, 4: consecutive data grants, while if_req is held high, after which fetch wins the next arbitration (legal range 1..15).

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  combinational, one cycle; fetch request accepted this cycle.
- if_done  out  1  registered one-cycle completion pulse for fetch.
- if_rdata  out  32  instruction word; valid only while if_done is high.
- d_req  in  1  data request; held high with d_addr/d_we/d_wdata stable until d_gnt.
- d_addr  in  32  data word address.
- d_we  in  4  byte write enables; 4'b0000 means read.
- d_wdata  in  32  byte-lane-aligned store data.
- d_gnt  out  1  combinational, one cycle; data request accepted.
- d_done  out  1  registered one-cycle completion pulse for data.
- d_rdata  out  32  load word; valid while d_done is high; 0 for writes.
- err  out  1  high together with if_done/d_done when the transaction timed out.
- mem_en  out  1  memory access strobe.
- mem_wea  out  4  memory byte write enables.
- mem_addr  out  32  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, sampled on the edge where mem_ready is high.
- mem_ready  in  1  memory completion (MIO_ready).

## Operation

- States: IDLE, BUSY, RESP.
- Acceptance occurs only in IDLE or RESP; in BUSY both gnt outputs are 0.
- Arbitration, evaluated in IDLE or RESP:
  - If only one request is high, that request wins.
  - If both are high, data wins unless starve_cnt equals STARVE_MAX, in which case fetch wins.
- starve_cnt (4-bit):
  - Increments, saturating, on each data grant made while if_req is high.
  - Clears on any fetch grant.
  - Is unchanged otherwise.
- On acceptance, the owner, address, we and wdata are latched, the timeout counter clears, and the state moves to BUSY. For fetch, we is latched as 4'b0000.
- In BUSY:
  - mem_en is 1 and mem_addr/mem_wea/mem_wdata show the latched values, constant for the whole of BUSY.
  - The timeout counter increments each cycle.
- Exit from BUSY, sampled at the rising edge:
  - If mem_ready is 1, rdata is latched from mem_rdata (forced to 0 if we is nonzero), err is set to 0, and the state moves to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1, rdata is latched as 32'hDEADBEEF, err is set to 1, and the state moves to RESP.
- In RESP:
  - The owner's done output is 1 for exactly one cycle, with rdata and err valid.
  - mem_en is 0 and mem_wea is 0.
  - A new request may be accepted in this same cycle.
- When mem_en is 0, mem_wea is forced to 4'b0000. mem_addr and mem_wdata hold their last value.
- Addresses and data pass through unmodified. No alignment checking is done; the requester computes the byte lanes.

## Timing

- Reset values (asserted asynchronously): state IDLE, starve_cnt 0, timeout counter 0. All outputs are 0: mem_en, mem_wea, mem_addr, mem_wdata, if_done, d_done, err, if_rdata, d_rdata, and both gnt signals.
- Latency with a zero-wait memory (mem_ready high in the first BUSY cycle):
  - gnt in cycle T.
  - BUSY with mem_en in cycle T+1.
  - done in cycle T+2.
- Peak throughput is one transaction every 2 cycles, because the RESP cycle overlaps the next acceptance.
- Each cycle of mem_ready low in BUSY adds one cycle of latency.
- A timeout completes after exactly TIMEOUT_CYCLES BUSY cycles; done follows in the next cycle.
- A req that drops before its gnt is not an error; the request is simply not accepted.
- mem_ready high outside BUSY is ignored.
- If reset is asserted during BUSY or RESP, the transaction is abandoned and no done pulse is issued. After reset deasserts, operation resumes from IDLE on the first clock edge.

## Test plan

- Single fetch, addr 0x10, mem_ready tied high, mem_rdata 0x00500093: if_gnt in T, mem_en=1 with mem_addr=0x10 and mem_wea=0 in T+1, if_done=1 with if_rdata=0x00500093 and err=0 in T+2.
- Byte store: d_we=4'b0100, d_addr=0x20, d_wdata=0x00AB0000, mem_ready low for 3 BUSY cycles. mem_wea=0100 is held for 4 BUSY cycles, then d_done=1 with d_rdata=0.
- Simultaneous requests with STARVE_MAX=4, d_req and if_req held high continuously: the grant sequence is D,D,D,D,I,D,D,D,D,I,… with starve_cnt returning to 0 after each I.
- Timeout with TIMEOUT_CYCLES=8 and mem_ready never asserted on a data read: mem_en is high for exactly 8 cycles, then d_done=1, err=1, d_rdata=0xDEADBEEF, and the next request is accepted in the RESP cycle.
- Back-to-back fetches at 0x0 then 0x1, zero-wait memory: the second if_gnt coincides with the first if_done, and the second if_done arrives 2 cycles later.
- Reset pulled low during the second BUSY cycle of a load: all outputs are 0 immediately, no d_done occurs, and after release a fresh d_req is granted in the first cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch path
// and the load/store data path. One transaction is in flight at a time:
// IDLE/RESP accept a request, BUSY drives the memory port until mem_ready_i
// (or a timeout), RESP returns the read data with a one-cycle done pulse.
// Data has priority over fetch, except that after STARVE_MAX consecutive data
// grants made while fetch was waiting, fetch wins the next arbitration.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   if_req_i/if_addr_i         fetch request (held until if_gnt_o)
//   if_gnt_o                   combinational accept strobe for fetch
//   if_done_o/if_rdata_o       registered completion pulse + instruction word
//   d_req_i/d_addr_i/d_we_i/d_wdata_i   data request (d_we_i==0 means read)
//   d_gnt_o                    combinational accept strobe for data
//   d_done_o/d_rdata_o         registered completion pulse + load word
//   err_o                      high with the done pulse of a timed-out access
//   mem_en_o/mem_wea_o/mem_addr_o/mem_wdata_o   memory port
//   mem_rdata_i/mem_ready_i    memory read data and completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 2..255
  parameter int unsigned STARVE_MAX     = 4     // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // fetch requester
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  // data requester
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_we_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_done_o,
  output logic [31:0] d_rdata_o,
  output logic        err_o,
  // memory port
  output logic        mem_en_o,
  output logic [3:0]  mem_wea_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] TMO_RDATA  = 32'hDEAD_BEEF;

  state_e      state_q, state_d;
  logic        owner_d_q;      // 1: data path owns the transaction
  logic [31:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  tmo_q;
  logic [3:0]  starve_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        err_q;

  logic        can_accept;
  logic        fetch_wins;
  logic        accept;
  logic        tmo_hit;
  logic        busy_exit;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are combinational and also masked by reset so that
  // nothing is reported accepted while the block is held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    can_accept = rst_ni && (state_q != S_BUSY);
    fetch_wins = if_req_i && (!d_req_i || (starve_q == STARVE_LIM));
    if_gnt_o   = can_accept && fetch_wins;
    d_gnt_o    = can_accept && d_req_i && !fetch_wins;
    accept     = if_gnt_o || d_gnt_o;
    tmo_hit    = (tmo_q == TMO_LAST);
    busy_exit  = (state_q == S_BUSY) && (mem_ready_i || tmo_hit);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, regardless of evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned; that is what keeps a combinational block from becoming a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_RESP:  state_d = accept ? S_BUSY : S_IDLE;
      S_BUSY:  if (busy_exit) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction datapath, timeout counter, starvation counter, done pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_d_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      starve_q  <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        owner_d_q <= d_gnt_o;
        addr_q    <= d_gnt_o ? d_addr_i  : if_addr_i;
        we_q      <= d_gnt_o ? d_we_i    : 4'b0000;  // fetches are always reads
        wdata_q   <= d_gnt_o ? d_wdata_i : 32'h0;
        tmo_q     <= '0;
      end else if (state_q == S_BUSY) begin
        tmo_q <= tmo_q + 8'd1;
      end

      if (busy_exit) begin
        // A real ready beats a coincident timeout.
        if (mem_ready_i) rdata_q <= (we_q != 4'b0000) ? 32'h0 : mem_rdata_i;
        else             rdata_q <= TMO_RDATA;
      end

      // Done and err are pulses for the single RESP cycle that follows BUSY.
      if_done_q <= busy_exit && !owner_d_q;
      d_done_q  <= busy_exit &&  owner_d_q;
      err_q     <= busy_exit && !mem_ready_i;

      // Only data grants made while fetch was waiting count toward starvation.
      if (if_gnt_o)                                   starve_q <= '0;
      else if (d_gnt_o && if_req_i && starve_q != 4'hF) starve_q <= starve_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Address and write data keep their last value outside BUSY;
  // byte enables are forced off whenever the port is not strobed.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_o    = (state_q == S_BUSY);
    mem_wea_o   = mem_en_o ? we_q : 4'b0000;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_done_o   = if_done_q;
    d_done_o    = d_done_q;
    err_o       = err_q;
    if_rdata_o  = if_done_q ? rdata_q : 32'h0;
    d_rdata_o   = d_done_q  ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter.
// The reference model predicts, per cycle, whether an acceptance may happen and
// who wins, from the arbitration rules alone (cycle arithmetic and a starvation
// count). On every acceptance it pushes the expected memory-port activity and
// the expected completion into queues. A memory responder and a completion
// monitor pop and compare independently of the stimulus.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_en;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_done_o(if_done), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_done_o(d_done), .d_rdata_o(d_rdata),
    .err_o(err),
    .mem_en_o(mem_en), .mem_wea_o(mem_wea), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          delay;   // BUSY index at which the memory raises ready
    int          busy;    // expected number of BUSY cycles
  } mem_exp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          done_cyc;
  } rsp_exp_t;

  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] mem_img [logic [31:0]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int plan_delay = -1;   // -1: model picks a random memory delay

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Reference model: acceptance window, winner, starvation, expected results.
  // ---------------------------------------------------------------------------
  initial begin
    int  next_accept = 0;
    int  starve = 0;
    bit  win_i, win_d;
    int  dly, b;
    mem_exp_t m;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        starve = 0;
        next_accept = 0;
        check("gnt_in_reset", {30'd0, if_gnt, d_gnt}, 32'd0);
        continue;
      end
      if (cyc >= next_accept) begin
        win_i = if_req && (!d_req || starve == SM);
        win_d = d_req && !win_i;
        check("if_gnt", if_gnt, win_i);
        check("d_gnt", d_gnt, win_d);
        if (win_i || win_d) begin
          dly = (plan_delay >= 0) ? plan_delay
              : (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(6, 12)));
          b = (dly < TO) ? dly + 1 : TO;
          m.is_d  = win_d;
          m.addr  = win_d ? d_addr : if_addr;
          m.we    = win_d ? d_we : 4'b0000;
          m.wdata = d_wdata;
          m.delay = dly;
          m.busy  = b;
          mem_q.push_back(m);
          r.is_d     = win_d;
          r.err      = (dly >= TO);
          r.rdata    = r.err ? 32'hDEAD_BEEF : ((m.we != 4'b0000) ? 32'h0 : mem_word(m.addr));
          r.done_cyc = cyc + 1 + b;
          rsp_q.push_back(r);
          next_accept = cyc + 1 + b;
          if (win_i) starve = 0;
          else if (if_req && starve < 15) starve++;
        end
      end else begin
        check("gnt_while_busy", {30'd0, if_gnt, d_gnt}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory responder: checks the port during BUSY and supplies ready/rdata.
  // ---------------------------------------------------------------------------
  initial begin
    mem_exp_t cur;
    bit active = 0;
    int k = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
        mem_ready = 1'b0;
        continue;
      end
      if (mem_en) begin
        if (!active) begin
          check("mem_en_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) begin
            cur = mem_q.pop_front();
            active = 1;
            k = 0;
          end
        end else begin
          k++;
        end
        if (active) begin
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wea", mem_wea, cur.we);
          if (cur.is_d) check("mem_wdata", mem_wdata, cur.wdata);
          mem_ready = (k == cur.delay);
          mem_rdata = (k == cur.delay) ? mem_word(cur.addr) : $urandom;
        end
      end else begin
        if (active) begin
          check("busy_cycles", k + 1, cur.busy);
          active = 0;
        end
        check("mem_wea_idle", mem_wea, 4'b0000);
        mem_ready = 1'($urandom_range(0, 1));  // must be ignored outside BUSY
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion monitor.
  // ---------------------------------------------------------------------------
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (if_done || d_done) begin
        check("one_done_only", if_done && d_done, 1'b0);
        check("done_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          check("done_owner_is_d", d_done, e.is_d);
          check("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
          check("err", err, e.err);
          check("done_cycle", cyc, e.done_cyc);
        end
      end else begin
        check("err_without_done", err, 1'b0);
        if (rsp_q.size() != 0 && rsp_q[0].done_cyc < cyc) begin
          check("done_by_cycle", cyc, rsp_q[0].done_cyc);
          void'(rsp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_gnt(input bit is_d, input string name);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = is_d ? d_gnt : if_gnt;
    end
    check(name, got, 1'b1);
  endtask

  task automatic issue_if(input logic [31:0] a, input int dly);
    plan_delay = dly;
    if_req  = 1'b1;
    if_addr = a;
    wait_gnt(1'b0, "if_gnt_within_bound");
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd, input int dly);
    plan_delay = dly;
    d_req   = 1'b1;
    d_addr  = a;
    d_we    = we;
    d_wdata = wd;
    wait_gnt(1'b1, "d_gnt_within_bound");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_wea"}, mem_wea, 4'b0000);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_dones"}, {30'd0, if_done, d_done}, 32'd0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
    check({tag, "_gnts"}, {30'd0, if_gnt, d_gnt}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit gi, gd;
    int ngrant;
    mem_img[32'h10] = 32'h0050_0093;

    // Reset state, including grants masked while requests are high.
    #1;
    if_req = 1'b1;
    d_req  = 1'b1;
    #1;
    check_all_zero("reset");
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single zero-wait fetch; byte store with 3 wait cycles.
    issue_if(32'h10, 0);
    issue_d(32'h20, 4'b0100, 32'h00AB_0000, 3);

    // Timed-out read, then a fetch raised during BUSY is accepted in RESP.
    issue_d(32'h40, 4'b0000, 32'h0, 20);
    issue_if(32'h44, 0);

    // Back-to-back fetches.
    issue_if(32'h0, 0);
    issue_if(32'h1, 0);

    // Reset asserted in the second BUSY cycle of a load.
    plan_delay = 10;
    d_req  = 1'b1;
    d_addr = 32'h80;
    d_we   = 4'b0000;
    wait_gnt(1'b1, "d_gnt_before_reset");
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    rsp_q.delete();
    mem_q.delete();
    #1;
    check_all_zero("async_reset");
    plan_delay = 0;
    d_req  = 1'b1;
    d_addr = 32'h84;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("d_gnt_first_cycle_after_reset", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;

    // Both requesters held high: D,D,D,D,I repeating from a cleared count.
    plan_delay = 0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_addr  = 32'h200; d_we = 4'b0000;
    ngrant = 0;
    for (int i = 0; i < 60 && ngrant < 10; i++) begin
      @(negedge clk);
      gi = if_gnt;
      gd = d_gnt;
      if (gi || gd) begin
        check("starve_pattern_is_fetch", gi, (ngrant % 5) == 4);
        ngrant++;
      end
      @(posedge clk); #1;
      if (gi) if_addr = if_addr + 32'd1;
      if (gd) d_addr  = d_addr + 32'd4;
    end
    check("starve_pattern_grants", ngrant, 10);

    // Randomized traffic.
    plan_delay = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt;
      gd = d_gnt;
      @(posedge clk); #1;
      if (gi || !if_req) begin
        if ($urandom_range(0, 99) < 60) begin
          if_req  = 1'b1;
          if_addr = ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom;
        end else begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(0, 63) == 0) begin
        if_req = 1'b0;   // abandoned before grant
      end
      if (gd || !d_req) begin
        if ($urandom_range(0, 99) < 60) begin
          d_req   = 1'b1;
          d_addr  = $urandom;
          d_we    = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if ($urandom_range(0, 63) == 0) begin
        d_req = 1'b0;
      end
    end

    // Drain.
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 300 && rsp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
